// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } conv_state_t;

   localparam int unsigned NIB_W = 4;

   localparam logic [NIB_W-1:0] ADD3_THRESH = 4'd5;
   localparam logic [NIB_W-1:0] ADD3_VAL    = 4'd3;

   // 10^n. Used to confirm that the digit count can hold the largest input.
   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble nibble correction: a digit of 5 or more gets +3 before the shift.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [NIB_W-1:0] digit,
   output logic [NIB_W-1:0] corrected
);

   // The result never exceeds 12, so it always fits in the nibble.
   always_comb begin
      corrected = (digit >= ADD3_THRESH) ? digit + ADD3_VAL : digit;
   end

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential double-dabble converter: one correct-and-shift step per clock,
// with the packed BCD result held between conversions.
module bcd_seq_converter
   import bcd_pkg::*;
#(
   parameter int unsigned BIN_W  = 12,
   parameter int unsigned DIGITS = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [BIN_W-1:0]          bin_d_in,
   output logic [NIB_W*DIGITS-1:0]   bcd_d_out,
   output logic                      rdy,
   output logic                      busy
);

   localparam int unsigned BCD_W = NIB_W * DIGITS;
   localparam int unsigned IW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [IW-1:0] LAST_ITER = IW'(BIN_W - 1);
   localparam longint unsigned MAX_BIN = (64'd1 << BIN_W) - 64'd1;

   if (pow10(DIGITS) <= MAX_BIN) begin : g_range_check
      $error("bcd_seq_converter: DIGITS too small for BIN_W");
   end

   conv_state_t       state;
   conv_state_t       state_nx;
   logic [IW-1:0]     iter;
   logic [BCD_W-1:0]  scratch;
   logic [BIN_W-1:0]  shift_reg;
   logic [BCD_W-1:0]  corrected;
   logic [BCD_W-1:0]  scratch_nx;
   logic [BIN_W-1:0]  shift_nx;
   logic              load;
   logic              step;
   logic              done;

   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_add3_digit u_add3 (
         .digit     (scratch[g*NIB_W +: NIB_W]),
         .corrected (corrected[g*NIB_W +: NIB_W])
      );
   end

   // Left shift of {corrected scratch, shift_reg} by one bit.
   always_comb begin
      scratch_nx = {corrected[BCD_W-2:0], shift_reg[BIN_W-1]};
      shift_nx   = {shift_reg[BIN_W-2:0], 1'b0};
   end

   // Next-state and control decode.
   always_comb begin
      state_nx = state;
      load     = 1'b0;
      step     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               load     = 1'b1;
               state_nx = CONV;
            end
         end
         CONV: begin
            step = 1'b1;
            if (iter == LAST_ITER) begin
               done     = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath registers: capture, iterate, and publish the finished result.
   always_ff @(posedge clk) begin
      if (rst) begin
         iter      <= '0;
         scratch   <= '0;
         shift_reg <= '0;
         bcd_d_out <= '0;
         rdy       <= 1'b0;
      end else begin
         rdy <= done;
         if (load) begin
            shift_reg <= bin_d_in;
            scratch   <= '0;
            iter      <= '0;
         end else if (step) begin
            shift_reg <= shift_nx;
            scratch   <= scratch_nx;
            iter      <= iter + 1'b1;
         end
         if (done) begin
            bcd_d_out <= scratch_nx;
         end
      end
   end

   assign busy = (state == CONV);

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed self-checking bench for bcd_seq_converter (default 12-bit / 4 digits).
module tb_bcd_seq_converter;

   localparam int unsigned BIN_W  = 12;
   localparam int unsigned DIGITS = 4;

   logic                  clk;
   logic                  rst;
   logic                  en;
   logic [BIN_W-1:0]      bin_d_in;
   logic [4*DIGITS-1:0]   bcd_d_out;
   logic                  rdy;
   logic                  busy;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   bcd_seq_converter #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .bin_d_in  (bin_d_in),
      .bcd_d_out (bcd_d_out),
      .rdy       (rdy),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Pulse en for one edge with the given value and confirm the start was taken.
   task automatic start(input logic [BIN_W-1:0] value, input string tag);
      bin_d_in = value;
      en       = 1'b1;
      tick();
      en       = 1'b0;
      check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
   endtask

   // From just after the accepting edge: 11 quiet cycles, then rdy with the result.
   task automatic finish_conv(input logic [15:0] exp, input string tag, input bit trail);
      int unsigned bad_cycles;
      bad_cycles = 0;
      for (int i = 1; i < int'(BIN_W); i++) begin
         tick();
         if (rdy !== 1'b0 || busy !== 1'b1) bad_cycles++;
      end
      check({tag, "_quiet"}, bad_cycles, 32'd0);
      tick();
      check({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      check({tag, "_bcd"}, {16'd0, bcd_d_out}, {16'd0, exp});
      if (trail) begin
         tick();
         check({tag, "_rdy_pulse"}, {31'd0, rdy}, 32'd0);
         check({tag, "_bcd_hold"}, {16'd0, bcd_d_out}, {16'd0, exp});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned rdy_seen;
      rst      = 1'b1;
      en       = 1'b0;
      bin_d_in = '0;
      tick();
      tick();
      check("rst_bcd", {16'd0, bcd_d_out}, 32'h0000);
      check("rst_rdy", {31'd0, rdy}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick();

      start(12'd0, "zero");
      finish_conv(16'h0000, "zero", 1'b1);

      start(12'd1234, "v1234");
      finish_conv(16'h1234, "v1234", 1'b1);

      start(12'd4095, "v4095");
      finish_conv(16'h4095, "v4095", 1'b1);

      start(12'd9, "v9");
      finish_conv(16'h0009, "v9", 1'b1);
      start(12'd10, "v10");
      finish_conv(16'h0010, "v10", 1'b1);

      // en held high; input swapped right after capture must not disturb the result
      bin_d_in = 12'd7;
      en       = 1'b1;
      tick();
      check("b2b_busy0", {31'd0, busy}, 32'd1);
      bin_d_in = 12'd4000;
      finish_conv(16'h0007, "b2b_7", 1'b0);
      tick();
      check("b2b_busy1", {31'd0, busy}, 32'd1);
      check("b2b_rdy1", {31'd0, rdy}, 32'd0);
      bin_d_in = 12'd7;
      finish_conv(16'h4000, "b2b_4000", 1'b0);
      en = 1'b0;
      tick();
      check("b2b_end_rdy", {31'd0, rdy}, 32'd0);

      // en during CONV is ignored
      start(12'd321, "ign");
      tick();
      tick();
      bin_d_in = 12'd55;
      en       = 1'b1;
      tick();
      en       = 1'b0;
      rdy_seen = 0;
      for (int i = 4; i < int'(BIN_W); i++) begin
         tick();
         if (rdy === 1'b1) rdy_seen++;
      end
      check("ign_early_rdy", rdy_seen, 32'd0);
      tick();
      check("ign_rdy", {31'd0, rdy}, 32'd1);
      check("ign_bcd", {16'd0, bcd_d_out}, 32'h0321);
      tick();
      check("ign_no_restart", {31'd0, busy}, 32'd0);

      // reset aborts a conversion of 999
      start(12'd999, "abort");
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_bcd", {16'd0, bcd_d_out}, 32'h0000);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_rdy", {31'd0, rdy}, 32'd0);
      rdy_seen = 0;
      for (int i = 0; i < 14; i++) begin
         tick();
         if (rdy === 1'b1) rdy_seen++;
      end
      check("abort_no_rdy", rdy_seen, 32'd0);

      // reset and en together: reset wins
      rst      = 1'b1;
      en       = 1'b1;
      bin_d_in = 12'd999;
      tick();
      rst = 1'b0;
      en  = 1'b0;
      check("rst_en_busy", {31'd0, busy}, 32'd0);
      tick();
      check("rst_en_idle", {31'd0, busy}, 32'd0);

      start(12'd999, "v999");
      finish_conv(16'h0999, "v999", 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
